fetch_addr_sequencer: RTL

- Sequences the instruction-fetch address incrementer for the ibex simple system.
- Holds the fetch PC and issues word-aligned requests on the instruction-memory req/gnt/rvalid interface.
- Advances the PC by 4 per grant, redirects on branch, and limits outstanding requests by prefetch-FIFO credits.
- Pushes responses, tagged with their addresses, into the downstream prefetch FIFO; discards responses to requests issued before a branch.

---
 rtl/fetch_addr_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fetch_addr_sequencer.sv
// Instruction-fetch address sequencer: issues word-aligned requests on the
// req/gnt/rvalid bus under prefetch-FIFO credit control and tags responses.
module fetch_addr_sequencer #(
  parameter int unsigned           ADDR_W          = 32,
  parameter logic [ADDR_W-1:0]     BOOT_ADDR       = 32'h0010_0080,
  parameter int unsigned           MAX_OUTSTANDING = 2,
  parameter int unsigned           FIFO_DEPTH      = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  output logic              instr_req_o,
  output logic [ADDR_W-1:0] instr_addr_o,
  input  logic              instr_gnt_i,
  input  logic              instr_rvalid_i,
  input  logic              instr_err_i,
  output logic              fifo_push_o,
  output logic [ADDR_W-1:0] fifo_addr_o,
  output logic              fifo_err_o,
  output logic              fifo_clear_o,
  input  logic              fifo_pop_i,
  output logic              busy_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 2);
  localparam logic [ADDR_W-1:0] ALIGN_MASK   = ~(ADDR_W'(3));
  localparam logic [ADDR_W-1:0] BOOT_ALIGNED = BOOT_ADDR & ALIGN_MASK;
  localparam logic [CNT_W-1:0]  MAX_C        = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W:0]    DEPTH_C      = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, WAIT_GNT, ERR} state_e;

  state_e             state, state_next;
  logic [ADDR_W-1:0]  pc, pc_next;
  logic [ADDR_W-1:0]  rsp_addr;
  logic [ADDR_W-1:0]  pend_addr, pend_addr_next;
  logic               pend_valid, pend_valid_next;
  logic               err_pend, err_pend_next;
  logic [CNT_W-1:0]   outstanding, occ, discard;
  logic [CNT_W:0]     credit_sum;
  logic [ADDR_W-1:0]  target;
  logic               can_req, fire, rv, drop, push, pop, late_discard;

  assign target     = branch_addr_i & ALIGN_MASK;
  assign credit_sum = {1'b0, outstanding} + {1'b0, occ};
  assign can_req    = (outstanding < MAX_C) && (credit_sum < DEPTH_C);
  assign fire       = instr_req_o & instr_gnt_i;
  // rvalid with nothing outstanding is a leftover from before reset
  assign rv         = instr_rvalid_i & (outstanding != '0);
  assign drop       = rv & (branch_i | (discard != '0));
  assign push       = rv & ~drop;
  assign pop        = fifo_pop_i & ~branch_i & (occ != '0);

  assign instr_addr_o = pc & ALIGN_MASK;
  assign fifo_push_o  = push;
  assign fifo_addr_o  = rsp_addr;
  assign fifo_err_o   = push & instr_err_i;
  assign fifo_clear_o = branch_i;
  assign busy_o       = (outstanding != '0) || (state != IDLE);

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    instr_req_o     = 1'b0;
    late_discard    = 1'b0;
    pend_valid_next = pend_valid;
    pend_addr_next  = pend_addr;
    err_pend_next   = err_pend | (push & instr_err_i);
    case (state)
      IDLE: begin
        if (branch_i) pc_next = target;
        if (req_i) state_next = RUN;
      end
      RUN: begin
        instr_req_o = can_req & req_i & ~branch_i;
        if (branch_i) begin
          pc_next    = target;
          state_next = req_i ? RUN : IDLE;
        end else if (!req_i) begin
          state_next = IDLE;
        end else if (instr_req_o && !instr_gnt_i) begin
          state_next = WAIT_GNT;
        end else if (instr_req_o) begin
          pc_next = pc + ADDR_W'(4);
        end
      end
      WAIT_GNT: begin
        instr_req_o = 1'b1;
        if (instr_gnt_i) begin
          state_next      = RUN;
          pend_valid_next = 1'b0;
          if (branch_i) begin
            pc_next = target;
          end else if (pend_valid) begin
            // held request belongs to the pre-branch stream: drop its response
            pc_next      = pend_addr;
            late_discard = 1'b1;
          end else begin
            pc_next = pc + ADDR_W'(4);
          end
        end else if (branch_i) begin
          pend_valid_next = 1'b1;
          pend_addr_next  = target;
        end
      end
      ERR: begin
        if (branch_i) begin
          pc_next    = target;
          state_next = req_i ? RUN : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (branch_i) err_pend_next = 1'b0;
    // an error seen during a held request takes effect once the grant lands
    if (err_pend_next && !(state == WAIT_GNT && !instr_gnt_i)) begin
      state_next    = ERR;
      err_pend_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      pc          <= BOOT_ALIGNED;
      rsp_addr    <= BOOT_ALIGNED;
      pend_addr   <= '0;
      pend_valid  <= 1'b0;
      err_pend    <= 1'b0;
      outstanding <= '0;
      occ         <= '0;
      discard     <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      pend_addr   <= pend_addr_next;
      pend_valid  <= pend_valid_next;
      err_pend    <= err_pend_next;
      outstanding <= outstanding + CNT_W'(fire) - CNT_W'(rv);
      if (branch_i) begin
        rsp_addr <= target;
        occ      <= '0;
        discard  <= outstanding + CNT_W'(fire) - CNT_W'(rv);
      end else begin
        if (push) rsp_addr <= rsp_addr + ADDR_W'(4);
        occ     <= occ + CNT_W'(push) - CNT_W'(pop);
        discard <= discard - CNT_W'(rv & (discard != '0)) + CNT_W'(late_discard);
      end
    end
  end

endmodule
